// File: rtl/instr_mem_loader.sv
// Copies a block of words from a synchronous-read backing store into the OS/process instruction
// memory write port. Define LOADER_CHECKSUM_EN to accumulate a running checksum of written words.
module instr_mem_loader #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned PAGE_WIDTH   = 11,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  target_os_i,
  input  logic [DATA_WIDTH-1:0] src_addr_i,
  input  logic [DATA_WIDTH-1:0] dst_addr_i,
  input  logic [DATA_WIDTH-1:0] length_i,
  output logic                  disk_rd_en_o,
  output logic [DATA_WIDTH-1:0] disk_rd_addr_o,
  input  logic [DATA_WIDTH-1:0] disk_data_i,
  output logic                  write_flag_o,
  output logic                  write_os_o,
  output logic [DATA_WIDTH-1:0] read_address_o,
  output logic [DATA_WIDTH-1:0] input_instr_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [DATA_WIDTH-1:0] checksum_o
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StWrite, StFinish} state_e;

  localparam logic [DATA_WIDTH-1:0] One      = 1;
  localparam logic [DATA_WIDTH:0]   WideOne  = 1;
  localparam logic [DATA_WIDTH:0]   MaxIndex = WideOne << (PAGE_WIDTH - 1);
  localparam logic [2:0]            Lat      = 3'(READ_LATENCY);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]            lat_q, lat_d;
  logic [DATA_WIDTH-1:0] src_q, src_d;
  logic [DATA_WIDTH-1:0] dst_q, dst_d;
  logic [DATA_WIDTH-1:0] len_q, len_d;
  logic                  os_q, os_d;
  logic                  rd_en_q, rd_en_d;
  logic [DATA_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  wf_q, wf_d;
  logic                  wos_q, wos_d;
  logic [DATA_WIDTH-1:0] ra_q, ra_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH:0]   end_idx;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] cs_q, cs_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lat_d     = lat_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    os_d      = os_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    wf_d      = 1'b0;
    wos_d     = wos_q;
    ra_d      = ra_q;
    instr_d   = instr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    cs_d      = cs_q;
`endif
    // Last destination index, one bit wider so a huge dst/length cannot wrap past the check.
    end_idx   = {1'b0, dst_addr_i} + {1'b0, length_i} - WideOne;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (length_i == '0) begin
            done_d  = 1'b1;
            state_d = StFinish;
`ifdef LOADER_CHECKSUM_EN
            cs_d    = '0;
`endif
          end else if (end_idx > MaxIndex) begin
            err_d = 1'b1;
          end else begin
            src_d     = src_addr_i;
            dst_d     = dst_addr_i;
            len_d     = length_i;
            os_d      = target_os_i;
            cnt_d     = '0;
            busy_d    = 1'b1;
            rd_en_d   = 1'b1;
            rd_addr_d = src_addr_i;
            state_d   = StIssue;
`ifdef LOADER_CHECKSUM_EN
            cs_d      = '0;
`endif
          end
        end
      end
      StIssue: begin
        lat_d   = Lat;
        state_d = StWait;
      end
      StWait: begin
        if (lat_q == 3'd1) begin
          instr_d = disk_data_i;
          ra_d    = dst_q + cnt_q;
          wos_d   = os_q;
          wf_d    = 1'b1;
          state_d = StWrite;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      StWrite: begin
`ifdef LOADER_CHECKSUM_EN
        cs_d = cs_q + instr_q;
`endif
        if (cnt_q == len_q - One) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StFinish;
        end else begin
          cnt_d     = cnt_q + One;
          rd_en_d   = 1'b1;
          rd_addr_d = src_q + cnt_q + One;
          state_d   = StIssue;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      lat_q     <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      os_q      <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wf_q      <= 1'b0;
      wos_q     <= 1'b0;
      ra_q      <= '0;
      instr_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      cs_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lat_q     <= lat_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      os_q      <= os_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wf_q      <= wf_d;
      wos_q     <= wos_d;
      ra_q      <= ra_d;
      instr_q   <= instr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef LOADER_CHECKSUM_EN
      cs_q      <= cs_d;
`endif
    end
  end

  assign disk_rd_en_o   = rd_en_q;
  assign disk_rd_addr_o = rd_addr_q;
  assign write_flag_o   = wf_q;
  assign write_os_o     = wos_q;
  assign read_address_o = ra_q;
  assign input_instr_o  = instr_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign error_o        = err_q;
`ifdef LOADER_CHECKSUM_EN
  assign checksum_o     = cs_q;
`else
  assign checksum_o     = '0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: two instances (read latency 1 and 3) share stimulus; a cycle-indexed
// model predicts every output each cycle, and directed runs pin completion cycles and write counts.
`timescale 1ns/1ps
module tb_instr_mem_loader;

  localparam int LAT [2] = '{1, 3};
  localparam int KCopy = 0, KZero = 1, KErr = 2;

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, target_os = 1'b0;
  logic [31:0] src = '0, dst = '0, len = '0;

  logic        rd_en [2];
  logic [31:0] rd_addr [2];
  logic [31:0] ddata [2];
  logic        wf [2];
  logic        wos [2];
  logic [31:0] ra [2];
  logic [31:0] instr [2];
  logic        busy [2];
  logic        done [2];
  logic        err [2];
  logic [31:0] cs [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_mem_loader #(.DATA_WIDTH(32), .PAGE_WIDTH(11), .READ_LATENCY(1)) dut_l1 (
    .clk_i(clk), .reset_i(reset), .start_i(start), .target_os_i(target_os),
    .src_addr_i(src), .dst_addr_i(dst), .length_i(len),
    .disk_rd_en_o(rd_en[0]), .disk_rd_addr_o(rd_addr[0]), .disk_data_i(ddata[0]),
    .write_flag_o(wf[0]), .write_os_o(wos[0]), .read_address_o(ra[0]),
    .input_instr_o(instr[0]), .busy_o(busy[0]), .done_o(done[0]), .error_o(err[0]),
    .checksum_o(cs[0])
  );

  instr_mem_loader #(.DATA_WIDTH(32), .PAGE_WIDTH(11), .READ_LATENCY(3)) dut_l3 (
    .clk_i(clk), .reset_i(reset), .start_i(start), .target_os_i(target_os),
    .src_addr_i(src), .dst_addr_i(dst), .length_i(len),
    .disk_rd_en_o(rd_en[1]), .disk_rd_addr_o(rd_addr[1]), .disk_data_i(ddata[1]),
    .write_flag_o(wf[1]), .write_os_o(wos[1]), .read_address_o(ra[1]),
    .input_instr_o(instr[1]), .busy_o(busy[1]), .done_o(done[1]), .error_o(err[1]),
    .checksum_o(cs[1])
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'd100: return 32'h7000_0000;
      32'd101: return 32'h9400_0000;
      32'd102: return 32'h7400_001E;
      32'd200: return 32'hFFFF_FFFF;
      32'd201: return 32'h0000_0002;
      default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endcase
  endfunction

  // Backing stores: a read sampled at an edge appears LAT edges later; junk otherwise.
  logic [31:0] pipe1;
  logic [31:0] pipe3 [3];
  always @(posedge clk) begin
    pipe1    <= rd_en[0] ? word_at(rd_addr[0]) : 32'hBAD0_BAD0;
    pipe3[0] <= rd_en[1] ? word_at(rd_addr[1]) : 32'hBAD0_BAD0;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign ddata[0] = pipe1;
  assign ddata[1] = pipe3[2];

  // Model: per instance, a transaction descriptor plus the cycle index since acceptance.
  bit          m_active [2];
  int          m_n [2];
  int          m_kind [2];
  logic [31:0] m_src [2];
  logic [31:0] m_dst [2];
  logic [31:0] m_len [2];
  logic        m_os [2];
  logic [31:0] last_ra [2];
  logic        last_os [2];
  logic [31:0] last_in [2];

  function automatic int kind_of(input logic [31:0] d, input logic [31:0] l);
    if (l == 0) return KZero;
    if (({1'b0, d} + {1'b0, l} - 33'd1) > 33'd1024) return KErr;
    return KCopy;
  endfunction

  // Copy takes LAT+2 cycles per word; done appears in the cycle right after the last word.
  function automatic int t_of(input int i);
    return (m_kind[i] == KCopy) ? int'(m_len[i]) * (LAT[i] + 2) : 0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_active[i] <= 1'b0;
        m_n[i]      <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_active[i] && m_n[i] < t_of(i)) begin
          m_n[i] <= m_n[i] + 1;
        end else if (m_active[i] && m_kind[i] != KErr) begin
          m_active[i] <= 1'b0;
        end else if (start) begin
          m_active[i] <= 1'b1;
          m_n[i]      <= 0;
          m_kind[i]   <= kind_of(dst, len);
          m_src[i]    <= src;
          m_dst[i]    <= dst;
          m_len[i]    <= len;
          m_os[i]     <= target_os;
        end else begin
          m_active[i] <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (latency %0d) at %0t: got %h expected %h", name, LAT[inst], $time,
               act, exp);
    end
  endtask

  task automatic check_inst(input int i);
    int p, n, t, k, ph;
    logic e_busy, e_done, e_err, e_rd, e_wf, e_os, cs_ok;
    logic [31:0] e_rda, e_ra, e_in, e_cs;
    p = LAT[i] + 2;
    n = m_n[i];
    t = t_of(i);
    e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0; e_rd = 1'b0; e_wf = 1'b0; cs_ok = 1'b0;
    e_rda = '0; e_cs = '0;
    e_ra = last_ra[i]; e_os = last_os[i]; e_in = last_in[i];
    if (reset) begin
      e_ra = '0; e_os = 1'b0; e_in = '0;
    end else if (m_active[i]) begin
      if (m_kind[i] == KCopy) begin
        k = n / p;
        ph = n % p;
        e_busy = (n < t);
        e_done = (n == t);
        e_rd   = (n < t) && (ph == 0);
        e_rda  = m_src[i] + 32'(k);
        e_wf   = (n < t) && (ph == LAT[i] + 1);
        if (e_wf) begin
          e_ra = m_dst[i] + 32'(k);
          e_os = m_os[i];
          e_in = word_at(m_src[i] + 32'(k));
        end
        if (e_done) begin
          cs_ok = 1'b1;
          for (int j = 0; j < int'(m_len[i]); j++) e_cs += word_at(m_src[i] + 32'(j));
        end
      end else begin
        e_done = (m_kind[i] == KZero) && (n == 0);
        e_err  = (m_kind[i] == KErr) && (n == 0);
        cs_ok  = e_done;
      end
    end
    chk("busy", i, 32'(busy[i]), 32'(e_busy));
    chk("done", i, 32'(done[i]), 32'(e_done));
    chk("error", i, 32'(err[i]), 32'(e_err));
    chk("disk_rd_en", i, 32'(rd_en[i]), 32'(e_rd));
    if (e_rd) chk("disk_rd_addr", i, rd_addr[i], e_rda);
    chk("write_flag", i, 32'(wf[i]), 32'(e_wf));
    chk("read_address", i, ra[i], e_ra);
    chk("write_os", i, 32'(wos[i]), 32'(e_os));
    chk("input_instr", i, instr[i], e_in);
`ifdef LOADER_CHECKSUM_EN
    if (cs_ok) chk("checksum", i, cs[i], e_cs);
`else
    chk("checksum_tied", i, cs[i], 32'h0);
`endif
    last_ra[i] <= e_ra;
    last_os[i] <= e_os;
    last_in[i] <= e_in;
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) check_inst(i);
  end

  // One load; n1/n3 are the cycle indices (0 = cycle after acceptance) of the done/error pulse.
  task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                     input logic os, input bit want_err, input int n1, input int n3,
                     input int writes, input bit busy_start, input bit cs_chk,
                     input logic [31:0] cs_exp);
    int seen [2];
    int wc [2];
    logic [31:0] cs_at [2];
    seen = '{-1, -1};
    wc = '{0, 0};
    cs_at = '{32'h0, 32'h0};
    @(negedge clk);
    src = s; dst = d; len = l; target_os = os; start = 1'b1;
    for (int n = 0; n < 80 && (seen[0] < 0 || seen[1] < 0); n++) begin
      @(negedge clk);
      if (n == 0) start = 1'b0;
      if (busy_start && n == 2) begin
        src = 32'd7; dst = 32'd5; len = 32'd1; start = 1'b1;
      end
      if (busy_start && n == 3) start = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (wf[i]) wc[i]++;
        if (seen[i] < 0 && (want_err ? err[i] : done[i])) begin
          seen[i] = n;
          cs_at[i] = cs[i];
        end
      end
    end
    start = 1'b0;
    chk("end_cycle", 0, 32'(seen[0]), 32'(n1));
    chk("end_cycle", 1, 32'(seen[1]), 32'(n3));
    for (int i = 0; i < 2; i++) begin
      chk("write_count", i, 32'(wc[i]), 32'(writes));
      if (cs_chk) chk("checksum_at_done", i, cs_at[i], cs_exp);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_busy", i, 32'(busy[i]), 32'h0);
      chk("reset_write_flag", i, 32'(wf[i]), 32'h0);
      chk("reset_read_address", i, ra[i], 32'h0);
    end
    #2 reset = 1'b0;

    run(32'd100, 32'd0, 32'd3, 1'b1, 1'b0, 9, 15, 3, 1'b0, 1'b0, 32'h0);
    chk("basic_last_word", 0, instr[0], 32'h7400_001E);
    chk("basic_last_index", 1, ra[1], 32'd2);
    run(32'd0, 32'd1020, 32'd5, 1'b0, 1'b0, 15, 25, 5, 1'b0, 1'b0, 32'h0);
    chk("top_index", 1, ra[1], 32'd1024);
    run(32'd0, 32'd1024, 32'd2, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0, 32'h0);
    run(32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 32'h0);
    run(32'd50, 32'd500, 32'd4, 1'b1, 1'b0, 12, 20, 4, 1'b1, 1'b0, 32'h0);
`ifdef LOADER_CHECKSUM_EN
    run(32'd200, 32'd7, 32'd2, 1'b0, 1'b0, 6, 10, 2, 1'b0, 1'b1, 32'h0000_0001);
`else
    run(32'd200, 32'd7, 32'd2, 1'b0, 1'b0, 6, 10, 2, 1'b0, 1'b1, 32'h0000_0000);
`endif
    run(32'hFFFF_FFFF, 32'd1023, 32'd2, 1'b0, 1'b0, 6, 10, 2, 1'b0, 1'b0, 32'h0);
    run(32'd0, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 0, 0, 0, 1'b0, 1'b0, 32'h0);

    // Reset between edges while both instances sit in a write cycle (cycle 14).
    @(negedge clk);
    src = 32'd300; dst = 32'd10; len = 32'd6; target_os = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2;
    for (int i = 0; i < 2; i++) chk("pre_reset_write_flag", i, 32'(wf[i]), 32'h1);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("async_write_flag", i, 32'(wf[i]), 32'h0);
      chk("async_busy", i, 32'(busy[i]), 32'h0);
      chk("async_done", i, 32'(done[i]), 32'h0);
    end
    @(negedge clk);
    #2 reset = 1'b0;
    run(32'd100, 32'd0, 32'd3, 1'b1, 1'b0, 9, 15, 3, 1'b0, 1'b0, 32'h0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
